// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: control-word layout, bubble value, FSM encodings.
package id_ex_stage_pkg;

    // Packed control word, MSB first:
    // {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[1:0], Branch}
    localparam int unsigned CTRL_W = 9;

    localparam int unsigned CTRL_REG_WRITE = 8;
    localparam int unsigned CTRL_MEM_READ  = 7;
    localparam int unsigned CTRL_MEM_WRITE = 6;
    localparam int unsigned CTRL_MEM_TO_REG = 5;
    localparam int unsigned CTRL_ALU_SRC   = 4;
    localparam int unsigned CTRL_REG_DST   = 3;
    localparam int unsigned CTRL_ALU_OP_HI = 2;
    localparam int unsigned CTRL_ALU_OP_LO = 1;
    localparam int unsigned CTRL_BRANCH    = 0;

    // An all-zero control word does nothing in EX/MEM/WB.
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/id_ex_stage_load_use_detector.sv
// Combinational load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Kept separate so branch-in-ID logic can reuse it.
module id_ex_stage_load_use_detector #(
    parameter int unsigned REG_W = 5
) (
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hz
);

    // $0 is hard-wired, so a load targeting it never creates a dependency.
    always_comb begin
        hz = ex_valid && ex_mem_read && (ex_rt != '0) &&
             ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, PC / IF-ID stall enables and a
// saturating count of inserted load-use bubbles.
import id_ex_stage_pkg::*;

module id_ex_stage #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = id_ex_stage_pkg::CTRL_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  IF_ID_RegRs,
    input  logic [REG_W-1:0]  IF_ID_RegRt,
    input  logic [REG_W-1:0]  IF_ID_RegRd,
    input  logic [DATA_W-1:0] IF_ID_ReadData1,
    input  logic [DATA_W-1:0] IF_ID_ReadData2,
    input  logic [DATA_W-1:0] IF_ID_Imm,
    input  logic [CTRL_W-1:0] IF_ID_Ctrl,
    input  logic              Flush,
    input  logic              MemStall,
    output logic [REG_W-1:0]  ID_EX_RegRs,
    output logic [REG_W-1:0]  ID_EX_RegRt,
    output logic [REG_W-1:0]  ID_EX_RegRd,
    output logic [DATA_W-1:0] ID_EX_ReadData1,
    output logic [DATA_W-1:0] ID_EX_ReadData2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [CTRL_W-1:0] ID_EX_Ctrl,
    output logic              ID_EX_Valid,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic [CNT_W-1:0]  StallCount
);

    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hz, hz_eff;

    id_ex_stage_load_use_detector #(
        .REG_W (REG_W)
    ) u_load_use_detector (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q[CTRL_MEM_READ]),
        .ex_rt       (rt_q),
        .id_rs       (IF_ID_RegRs),
        .id_rt       (IF_ID_RegRt),
        .hz          (hz)
    );

    // A flush squashes the dependent instruction, so there is nothing left to stall for.
    always_comb begin
        hz_eff      = hz && !Flush;
        PCWrite     = !hz_eff && !MemStall;
        IF_ID_Write = PCWrite;
    end

    // Next state: memory stall holds everything, then flush, then load-use bubble, then load.
    always_comb begin
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!MemStall) begin
            if (Flush || hz_eff) begin
                rs_d    = '0;
                rt_d    = '0;
                rd_d    = '0;
                rd1_d   = '0;
                rd2_d   = '0;
                imm_d   = '0;
                ctrl_d  = BUBBLE_CTRL;
                valid_d = 1'b0;
                if (Flush) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STALL;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end else begin
                rs_d    = IF_ID_RegRs;
                rt_d    = IF_ID_RegRt;
                rd_d    = IF_ID_RegRd;
                rd1_d   = IF_ID_ReadData1;
                rd2_d   = IF_ID_ReadData2;
                imm_d   = IF_ID_Imm;
                ctrl_d  = IF_ID_Ctrl;
                valid_d = 1'b1;
                state_d = ST_RUN;
            end
        end
    end

    // Pipeline register bank, FSM state and stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // After a bubble EX holds nothing, so a hazard seen in STALL means the bubble was lost.
    hz_in_stall_a: assert property (@(posedge clk) disable iff (reset)
        !((state_q == ST_STALL) && hz));

    assign ID_EX_RegRs     = rs_q;
    assign ID_EX_RegRt     = rt_q;
    assign ID_EX_RegRd     = rd_q;
    assign ID_EX_ReadData1 = rd1_q;
    assign ID_EX_ReadData2 = rd2_q;
    assign ID_EX_Imm       = imm_q;
    assign ID_EX_Ctrl      = ctrl_q;
    assign ID_EX_Valid     = valid_q;
    assign StallCount      = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use stall, $0 / store cases, flush priority,
// memory stall freeze, reset mid-stall and counter saturation (second instance, CNT_W=2).
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [8:0] C_LW  = 9'h1B0; // RegWrite MemRead MemToReg ALUSrc
    localparam logic [8:0] C_ADD = 9'h10C; // RegWrite RegDst ALUOp=10
    localparam logic [8:0] C_SW  = 9'h050; // MemWrite ALUSrc

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic [8:0]  ctrl;
    logic        flush, mem_stall;

    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_d1, ex_d2, ex_imm;
    logic [8:0]  ex_ctrl;
    logic        ex_valid, pc_write, ifid_write;
    logic [15:0] stall_cnt;

    logic [4:0]  s_rs, s_rt, s_rd;
    logic [31:0] s_d1, s_d2, s_imm;
    logic [8:0]  s_ctrl;
    logic        s_valid, s_pc_write, s_ifid_write;
    logic [1:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .IF_ID_RegRs(rs), .IF_ID_RegRt(rt), .IF_ID_RegRd(rd),
        .IF_ID_ReadData1(d1), .IF_ID_ReadData2(d2), .IF_ID_Imm(imm), .IF_ID_Ctrl(ctrl),
        .Flush(flush), .MemStall(mem_stall),
        .ID_EX_RegRs(ex_rs), .ID_EX_RegRt(ex_rt), .ID_EX_RegRd(ex_rd),
        .ID_EX_ReadData1(ex_d1), .ID_EX_ReadData2(ex_d2), .ID_EX_Imm(ex_imm),
        .ID_EX_Ctrl(ex_ctrl), .ID_EX_Valid(ex_valid),
        .PCWrite(pc_write), .IF_ID_Write(ifid_write), .StallCount(stall_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .IF_ID_RegRs(rs), .IF_ID_RegRt(rt), .IF_ID_RegRd(rd),
        .IF_ID_ReadData1(d1), .IF_ID_ReadData2(d2), .IF_ID_Imm(imm), .IF_ID_Ctrl(ctrl),
        .Flush(flush), .MemStall(mem_stall),
        .ID_EX_RegRs(s_rs), .ID_EX_RegRt(s_rt), .ID_EX_RegRd(s_rd),
        .ID_EX_ReadData1(s_d1), .ID_EX_ReadData2(s_d2), .ID_EX_Imm(s_imm),
        .ID_EX_Ctrl(s_ctrl), .ID_EX_Valid(s_valid),
        .PCWrite(s_pc_write), .IF_ID_Write(s_ifid_write), .StallCount(s_cnt)
    );

    // Advance one clock; sample/drive 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input logic [8:0] k);
        rs = a; rt = b; rd = c; d1 = x; d2 = y; imm = z; ctrl = k;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, C_ADD);
        flush = 1'b0; mem_stall = 1'b0;
        reset = 1'b1;
        #12;
        checks++;
        if ({ex_rs, ex_rt, ex_rd, ex_ctrl, ex_valid} !== 25'd0 ||
            {ex_d1, ex_d2, ex_imm} !== 96'd0) begin
            errors++; $display("FAIL reset_regs: ctrl=%h valid=%b d1=%h, want all zero",
                               ex_ctrl, ex_valid, ex_d1);
        end
        checks++;
        if (stall_cnt !== 16'd0 || pc_write !== 1'b1 || ifid_write !== 1'b1) begin
            errors++; $display("FAIL reset_cnt_en: cnt=%0d pcw=%b ifw=%b, want 0 1 1",
                               stall_cnt, pc_write, ifid_write);
        end
        checks++;
        if (dut.state_q !== ST_RUN) begin
            errors++; $display("FAIL reset_state: got %0d want RUN", dut.state_q);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_load_use();
        set_id(5'd29, 5'd8, 5'd0, 32'h1000, 32'h0, 32'h4, C_LW);
        step();
        set_id(5'd8, 5'd10, 5'd9, 32'hAAAA, 32'hBBBB, 32'h0, C_ADD);
        #1;
        checks++;
        if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
            errors++; $display("FAIL lu_enables: pcw=%b ifw=%b want 0 0", pc_write, ifid_write);
        end
        step();
        checks++;
        if (ex_ctrl !== 9'd0 || ex_valid !== 1'b0 || ex_rs !== 5'd0) begin
            errors++; $display("FAIL lu_bubble: ctrl=%h valid=%b rs=%0d want 0 0 0",
                               ex_ctrl, ex_valid, ex_rs);
        end
        checks++;
        if (stall_cnt !== 16'd1 || dut.state_q !== ST_STALL || pc_write !== 1'b1) begin
            errors++; $display("FAIL lu_count: cnt=%0d state=%0d pcw=%b want 1 STALL 1",
                               stall_cnt, dut.state_q, pc_write);
        end
        step();
        checks++;
        if (ex_rs !== 5'd8 || ex_rt !== 5'd10 || ex_rd !== 5'd9 || ex_valid !== 1'b1 ||
            ex_ctrl !== C_ADD || ex_d1 !== 32'hAAAA || ex_d2 !== 32'hBBBB) begin
            errors++; $display("FAIL lu_reissue: rs=%0d rt=%0d rd=%0d valid=%b ctrl=%h d1=%h",
                               ex_rs, ex_rt, ex_rd, ex_valid, ex_ctrl, ex_d1);
        end
        checks++;
        if (dut.state_q !== ST_RUN || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_after: state=%0d cnt=%0d want RUN 1",
                               dut.state_q, stall_cnt);
        end
    endtask

    task automatic test_no_hazard();
        set_id(5'd29, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, C_LW); // lw $0
        step();
        set_id(5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0, C_ADD);
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL nh_reg0: pcw=%b want 1", pc_write);
        end
        set_id(5'd29, 5'd8, 5'd0, 32'h0, 32'h5, 32'hC, C_SW); // sw $8
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_SW) begin
            errors++; $display("FAIL nh_sw_loaded: valid=%b ctrl=%h want 1 %h",
                               ex_valid, ex_ctrl, C_SW);
        end
        set_id(5'd8, 5'd8, 5'd12, 32'h0, 32'h0, 32'h0, C_ADD);
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL nh_store: pcw=%b want 1", pc_write);
        end
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || stall_cnt !== 16'd1) begin
            errors++; $display("FAIL nh_count: valid=%b rd=%0d cnt=%0d want 1 12 1",
                               ex_valid, ex_rd, stall_cnt);
        end
    endtask

    task automatic test_flush();
        set_id(5'd29, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
        step();
        set_id(5'd8, 5'd3, 5'd4, 32'h7, 32'h7, 32'h0, C_ADD);
        flush = 1'b1;
        #1;
        checks++;
        if (pc_write !== 1'b1) begin
            errors++; $display("FAIL fl_pcw: pcw=%b want 1", pc_write);
        end
        step();
        flush = 1'b0;
        checks++;
        if (ex_ctrl !== 9'd0 || ex_valid !== 1'b0 || ex_d1 !== 32'd0) begin
            errors++; $display("FAIL fl_bubble: ctrl=%h valid=%b d1=%h want 0", ex_ctrl,
                               ex_valid, ex_d1);
        end
        checks++;
        if (stall_cnt !== 16'd1 || dut.state_q !== ST_RUN) begin
            errors++; $display("FAIL fl_state: cnt=%0d state=%0d want 1 RUN",
                               stall_cnt, dut.state_q);
        end
    endtask

    task automatic test_mem_stall();
        set_id(5'd5, 5'd6, 5'd7, 32'h55, 32'h66, 32'h77, C_ADD);
        step();
        set_id(5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 32'h99, C_SW);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
                errors++; $display("FAIL ms_en[%0d]: pcw=%b ifw=%b want 0 0", i, pc_write,
                                   ifid_write);
            end
            step();
            checks++;
            if (ex_rs !== 5'd5 || ex_d1 !== 32'h55 || ex_imm !== 32'h77 ||
                ex_ctrl !== C_ADD || ex_valid !== 1'b1 || stall_cnt !== 16'd1) begin
                errors++; $display("FAIL ms_hold[%0d]: rs=%0d d1=%h ctrl=%h cnt=%0d", i,
                                   ex_rs, ex_d1, ex_ctrl, stall_cnt);
            end
        end
        mem_stall = 1'b0;
        step();
        checks++;
        if (ex_rs !== 5'd1 || ex_d1 !== 32'hDEAD || ex_ctrl !== C_SW) begin
            errors++; $display("FAIL ms_resume: rs=%0d d1=%h ctrl=%h want 1 dead %h",
                               ex_rs, ex_d1, ex_ctrl, C_SW);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_id(5'd29, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
        step();
        set_id(5'd4, 5'd8, 5'd9, 32'h1, 32'h2, 32'h0, C_ADD);
        step();
        checks++;
        if (dut.state_q !== ST_STALL || stall_cnt !== 16'd2) begin
            errors++; $display("FAIL rm_enter: state=%0d cnt=%0d want STALL 2",
                               dut.state_q, stall_cnt);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (dut.state_q !== ST_RUN || stall_cnt !== 16'd0 || ex_valid !== 1'b0 ||
            ex_ctrl !== 9'd0) begin
            errors++; $display("FAIL rm_async: state=%0d cnt=%0d valid=%b ctrl=%h",
                               dut.state_q, stall_cnt, ex_valid, ex_ctrl);
        end
        #1;
        reset = 1'b0;
        step();
        checks++;
        if (ex_rs !== 5'd4 || ex_valid !== 1'b1 || stall_cnt !== 16'd0 ||
            dut.state_q !== ST_RUN) begin
            errors++; $display("FAIL rm_next: rs=%0d valid=%b cnt=%0d state=%0d",
                               ex_rs, ex_valid, stall_cnt, dut.state_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_sat [5];
        exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
        exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_id(5'd29, 5'd8, 5'd0, 32'h0, 32'h0, 32'h0, C_LW);
            step();
            set_id(5'd8, 5'd10, 5'd9, 32'h0, 32'h0, 32'h0, C_ADD);
            step();
            checks++;
            if (s_cnt !== exp_sat[i] || stall_cnt !== 16'(i + 1)) begin
                errors++; $display("FAIL b2b_cnt[%0d]: sat=%0d full=%0d want %0d %0d", i,
                                   s_cnt, stall_cnt, exp_sat[i], i + 1);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_mem_stall();
        test_reset_mid_stall();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
